// File: rtl/count_display_pkg.sv
// Shared types and segment constants for the count_display block.
package count_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/count_display_seg7_decode.sv
// BCD digit to active-low 7-segment pattern; non-BCD codes blank the digit.
module seg7_decode
    import count_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_display.sv
// Binary count -> BCD (serial double-dabble) -> 2-digit multiplexed 7-seg.
// Optional LZ_BLANK_EN blanks a leading zero in the tens position.
module count_display
    import count_display_pkg::*;
#(
    parameter int CNT_W    = 6,
    parameter int SCAN_DIV = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count,
    output logic [6:0]       seg,
    output logic [1:0]       an,
    output logic             bcd_valid
);

    localparam int SR_W = 8 + CNT_W;
    localparam int IT_W = $clog2(CNT_W + 1);
    localparam int PS_W = $clog2(SCAN_DIV);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  last_conv;
    logic              dirty;
    logic [SR_W-1:0]   sr, sr_nxt, sr_adj;
    logic [IT_W-1:0]   iter;
    logic [3:0]        tens, ones;
    logic [PS_W-1:0]   prescaler;
    logic              dsel;
    logic              capture, load;
    logic              stale;
    logic [3:0]        digit;
    logic [6:0]        dec_seg, seg_nxt;

    // Sampler runs through reset so the first conversion sees the live count
    always_ff @(posedge clk) begin
        cnt_q <= count;
    end

    assign stale = (cnt_q != last_conv);

    always_comb begin
        sr_adj = sr;
        sr_adj[SR_W-1 -: 4]  = add3(sr[SR_W-1 -: 4]);
        sr_adj[CNT_W+3 -: 4] = add3(sr[CNT_W+3 -: 4]);
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        capture   = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (dirty || stale) begin
                    capture   = 1'b1;
                    sr_nxt    = {8'd0, cnt_q};
                    state_nxt = CONV;
                end
            end
            CONV: begin
                sr_nxt = {sr_adj[SR_W-2:0], 1'b0};
                if (iter == IT_W'(CNT_W - 1))
                    state_nxt = LOAD;
            end
            LOAD: begin
                load      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sr        <= '0;
            iter      <= '0;
            last_conv <= '0;
            dirty     <= 1'b1;
            tens      <= 4'd0;
            ones      <= 4'd0;
            bcd_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            if (capture) begin
                last_conv <= cnt_q;
                iter      <= '0;
            end else if (state == CONV) begin
                iter <= iter + 1'b1;
            end
            if (capture)
                dirty <= 1'b0;
            else if (stale)
                dirty <= 1'b1;
            if (load) begin
                tens <= sr[SR_W-1 -: 4];
                ones <= sr[CNT_W+3 -: 4];
            end
            if (stale)
                bcd_valid <= 1'b0;
            else if (load)
                bcd_valid <= 1'b1;
        end
    end

    assign digit = dsel ? tens : ones;

    seg7_decode u_dec (
        .digit (digit),
        .seg   (dec_seg)
    );

`ifdef LZ_BLANK_EN
    assign seg_nxt = (dsel && tens == 4'd0) ? SEG_BLANK : dec_seg;
`else
    assign seg_nxt = dec_seg;
`endif

    // seg and an are registered together so a digit never shows the other's pattern
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            dsel      <= 1'b0;
            seg       <= SEG_BLANK;
            an        <= 2'b11;
        end else begin
            if (prescaler == PS_W'(SCAN_DIV - 1)) begin
                prescaler <= '0;
                dsel      <= ~dsel;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            an  <= dsel ? 2'b01 : 2'b10;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display with SCAN_DIV=4, CNT_W=6.
module tb_count_display;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] count = 6'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       bcd_valid;

    int tests = 0;
    int fails = 0;

    count_display #(.CNT_W(6), .SCAN_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .seg       (seg),
        .an        (an),
        .bcd_valid (bcd_valid)
    );

    always #5 clk = ~clk;

    task automatic wait_an(input logic [1:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (an === want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            if (bcd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        bit ok;
        reset = 1'b0;
        count = 6'd20;
        repeat (3) @(negedge clk);
        tests++;
        if (seg !== 7'h7F) begin
            fails++;
            $display("FAIL rst_seg got=%h exp=7f", seg);
        end
        tests++;
        if (an !== 2'b11) begin
            fails++;
            $display("FAIL rst_an got=%b exp=11", an);
        end
        tests++;
        if (bcd_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_valid got=%b exp=0", bcd_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (an !== 2'b10) begin
            fails++;
            $display("FAIL first_an got=%b exp=10", an);
        end
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bcd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (bcd_valid === 1'b1) ok = 1'b1;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rst_conv_latency valid=%b exp=1", bcd_valid);
        end
    endtask

    task automatic test_scan;
        bit ok1, ok2;
        wait_an(2'b01, ok1);
        wait_an(2'b10, ok2);
        tests++;
        if (!ok1 || !ok2 || seg !== 7'h40) begin
            fails++;
            $display("FAIL scan_ones seg=%h exp=40 found=%0d%0d", seg, ok1, ok2);
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (an !== 2'b10) begin
                fails++;
                $display("FAIL scan_hold k=%0d an=%b exp=10", k, an);
            end
        end
        @(negedge clk);
        tests++;
        if (an !== 2'b01 || seg !== 7'h24) begin
            fails++;
            $display("FAIL scan_tens an=%b seg=%h exp=01/24", an, seg);
        end
    endtask

    task automatic test_extremes;
        bit ok;
        count = 6'd63;
        wait_valid(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL valid63 got=%b exp=1", bcd_valid);
        end
        wait_an(2'b10, ok);
        tests++;
        if (!ok || seg !== 7'h30) begin
            fails++;
            $display("FAIL ones63 seg=%h exp=30", seg);
        end
        wait_an(2'b01, ok);
        tests++;
        if (!ok || seg !== 7'h02) begin
            fails++;
            $display("FAIL tens63 seg=%h exp=02", seg);
        end
        count = 6'd0;
        wait_valid(ok);
        wait_an(2'b10, ok);
        tests++;
        if (!ok || seg !== 7'h40) begin
            fails++;
            $display("FAIL ones0 seg=%h exp=40", seg);
        end
        wait_an(2'b01, ok);
        tests++;
        if (!ok || seg !== 7'h40) begin
            fails++;
            $display("FAIL tens0 seg=%h exp=40", seg);
        end
    endtask

    task automatic test_midconv_change;
        bit ok;
        @(negedge clk);
        count = 6'd20;
        repeat (5) @(negedge clk);
        count = 6'd21;
        repeat (4) @(negedge clk);
        tests++;
        if (bcd_valid !== 1'b0) begin
            fails++;
            $display("FAIL stale_valid got=%b exp=0", bcd_valid);
        end
        wait_an(2'b10, ok);
        tests++;
        if (!ok || seg !== 7'h40) begin
            fails++;
            $display("FAIL old_ones seg=%h exp=40", seg);
        end
        ok = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (bcd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL reconv_valid got=%b exp=1", bcd_valid);
        end
        wait_an(2'b10, ok);
        tests++;
        if (!ok || seg !== 7'h79) begin
            fails++;
            $display("FAIL new_ones seg=%h exp=79", seg);
        end
    endtask

    task automatic test_reset_midconv;
        bit ok;
        count = 6'd45;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (seg !== 7'h7F || an !== 2'b11 || bcd_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrst seg=%h an=%b valid=%b exp=7f/11/0",
                     seg, an, bcd_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        tests++;
        if (an !== 2'b11) begin
            fails++;
            $display("FAIL midrst_hold an=%b exp=11", an);
        end
        wait_valid(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL midrst_valid got=%b exp=1", bcd_valid);
        end
        wait_an(2'b10, ok);
        tests++;
        if (!ok || seg !== 7'h12) begin
            fails++;
            $display("FAIL ones45 seg=%h exp=12", seg);
        end
        wait_an(2'b01, ok);
        tests++;
        if (!ok || seg !== 7'h19) begin
            fails++;
            $display("FAIL tens45 seg=%h exp=19", seg);
        end
    endtask

    task automatic test_leading_zero;
        bit ok;
        logic [6:0] exp_tens;
`ifdef LZ_BLANK_EN
        exp_tens = 7'h7F;
`else
        exp_tens = 7'h40;
`endif
        count = 6'd7;
        wait_valid(ok);
        wait_an(2'b10, ok);
        tests++;
        if (!ok || seg !== 7'h78) begin
            fails++;
            $display("FAIL ones7 seg=%h exp=78", seg);
        end
        wait_an(2'b01, ok);
        tests++;
        if (!ok || seg !== exp_tens) begin
            fails++;
            $display("FAIL tens7 seg=%h exp=%h", seg, exp_tens);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_extremes();
        test_midconv_change();
        test_reset_midconv();
        test_leading_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
